pet_event_arbiter: RTL and testbench

- Front-end controller for the virtual-pet state_UpDown FSM.
- Captures user buttons (food, heal, state step, test toggle), sensor signals (light, echo) and an internal periodic decay tick as pending requests.
- Arbitrates them by fixed priority and issues one command at a time to the pet FSM over a valid/ready handshake, followed by a cooldown.
- Owns the test-mode flag and gates which requests are legal in each mode.

---
 rtl/pet_pkg.sv | 49 ++++
 rtl/pet_event_arbiter_if.sv | 9 +
 rtl/pet_tick_gen.sv | 33 +++
 rtl/pet_event_arbiter.sv | 121 ++++++++++++
 tb/tb_pet_event_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pet_pkg.sv
// rtl/pet_pkg.sv - command codes, arbiter states, priority order and mode masks
package pet_pkg;

  localparam int NUM_REQ = 6;

  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_DECAY      = 3'd1,
    CMD_HEAL       = 3'd2,
    CMD_FOOD       = 3'd3,
    CMD_STATE_STEP = 3'd4,
    CMD_LIGHT      = 3'd5,
    CMD_ECHO       = 3'd6
  } cmd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_COOL  = 2'd2
  } arb_state_e;

  // Element 0 is the highest priority.
  localparam logic [NUM_REQ-1:0][2:0] PRIO_ORDER = {
    CMD_ECHO, CMD_LIGHT, CMD_STATE_STEP, CMD_FOOD, CMD_HEAL, CMD_DECAY
  };

  // Pending/request bit index is code-1.
  localparam logic [NUM_REQ-1:0] NORMAL_MASK     = 6'b110111;
  localparam logic [NUM_REQ-1:0] TEST_MASK       = 6'b001110;
  localparam logic [NUM_REQ-1:0] TOGGLE_CLR_MASK = 6'b111001;

  function automatic logic [NUM_REQ-1:0] code_onehot(input cmd_code_e c);
    logic [NUM_REQ-1:0] m;
    m = '0;
    for (int b = 0; b < NUM_REQ; b++)
      if (3'(b + 1) == c) m[b] = 1'b1;
    return m;
  endfunction

  function automatic cmd_code_e pick_cmd(input logic [NUM_REQ-1:0] pend);
    cmd_code_e c;
    c = CMD_NONE;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if ((pend & code_onehot(cmd_code_e'(PRIO_ORDER[i]))) != '0)
        c = cmd_code_e'(PRIO_ORDER[i]);
    return c;
  endfunction

endpackage

// File: rtl/pet_event_arbiter_if.sv
// rtl/pet_event_arbiter_if.sv - command handshake between the arbiter and the pet FSM
interface pet_event_arbiter_if;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pet_tick_gen.sv
// rtl/pet_tick_gen.sv - periodic decay tick; hold or clear parks the counter at zero
module pet_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (hold || clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pet_event_arbiter.sv
// rtl/pet_event_arbiter.sv - request capture, mode gating and command arbiter for the pet FSM
module pet_event_arbiter
  import pet_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int COOLDOWN = 4,
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                food_button,
  input  logic                heal_button,
  input  logic                state_button,
  input  logic                test_signal,
  input  logic                light_signal,
  input  logic                echo_signal,
  pet_event_arbiter_if.master cmd,
  output logic                test_mode,
  output logic [NUM_REQ-1:0]  pending,
  output logic [DROP_W-1:0]   drop_cnt
);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] COOL_LAST = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  logic [NUM_REQ-1:0] in_q, in_d, hist_q, hist_d, rise;
  logic [NUM_REQ-1:0] pending_q, pending_d, req, grant, clr_mask;
  logic               test_mode_q, test_mode_d, toggle, tick;
  logic [DROP_W-1:0]  drop_q, drop_d;
  arb_state_e         state_q, state_d;
  cmd_code_e          code_q, code_d;
  logic               valid_q, valid_d;
  logic [CW-1:0]      cool_q, cool_d;

  pet_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .hold (test_mode_q),
    .clr  (toggle),
    .tick (tick)
  );

  // Bit 0 of the captured inputs is test_signal; in the request vector bit 0 is the decay tick.
  always_comb begin
    in_d        = {echo_signal, light_signal, state_button, food_button, heal_button, test_signal};
    hist_d      = in_q;
    rise        = in_q & ~hist_q;
    toggle      = rise[0];
    req         = {rise[NUM_REQ-1:1], tick} & (test_mode_q ? TEST_MASK : NORMAL_MASK);
    clr_mask    = grant | (toggle ? TOGGLE_CLR_MASK : '0);
    pending_d   = (pending_q & ~clr_mask) | req;
    test_mode_d = test_mode_q ^ toggle;
    drop_d      = drop_q;
    for (int b = 0; b < NUM_REQ; b++)
      if (req[b] && pending_q[b] && (drop_d != '1)) drop_d = drop_d + DROP_W'(1);
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    cool_d  = cool_q;
    grant   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          code_d  = pick_cmd(pending_q);
          grant   = code_onehot(code_d);
          valid_d = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (valid_q && cmd.cmd_ready) begin
          valid_d = 1'b0;
          code_d  = CMD_NONE;
          if (COOLDOWN == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOL;
            cool_d  = COOL_LAST;
          end
        end
      end
      ST_COOL: begin
        if (cool_q == '0) state_d = ST_IDLE;
        else              cool_d  = cool_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q        <= '0;
      hist_q      <= '0;
      pending_q   <= '0;
      test_mode_q <= 1'b0;
      drop_q      <= '0;
      state_q     <= ST_IDLE;
      code_q      <= CMD_NONE;
      valid_q     <= 1'b0;
      cool_q      <= '0;
    end else begin
      in_q        <= in_d;
      hist_q      <= hist_d;
      pending_q   <= pending_d;
      test_mode_q <= test_mode_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      cool_q      <= cool_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_code  = code_q;
  assign test_mode     = test_mode_q;
  assign pending       = pending_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_pet_event_arbiter.sv
// tb/tb_pet_event_arbiter.sv - directed table and sequence bench for pet_event_arbiter
module tb_pet_event_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       food = 1'b0, heal = 1'b0, state_b = 1'b0, test_s = 1'b0, light = 1'b0, echo = 1'b0;
  logic       test_mode;
  logic [5:0] pending;
  logic [7:0] drop_cnt;
  int         checks = 0;
  int         failures = 0;

  pet_event_arbiter_if cmd_if ();

  pet_event_arbiter #(.TICK_DIV(16), .COOLDOWN(2), .DROP_W(8)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .food_button  (food),
    .heal_button  (heal),
    .state_button (state_b),
    .test_signal  (test_s),
    .light_signal (light),
    .echo_signal  (echo),
    .cmd          (cmd_if),
    .test_mode    (test_mode),
    .pending      (pending),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] in;   // {food, heal, state, test, light, echo, ready}
    logic       valid;
    logic [2:0] code;
    logic       tm;
    logic [5:0] pend;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [6:0] in, input logic valid, input logic [2:0] code,
                     input logic tm, input logic [5:0] pend, input logic [7:0] drop);
    vec_t r;
    r.in = in; r.valid = valid; r.code = code; r.tm = tm; r.pend = pend; r.drop = drop;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [6:0] in);
    @(negedge clk);
    {food, heal, state_b, test_s, light, echo, cmd_if.cmd_ready} = in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [7:0] prev_drop;
    logic       mono_ok;

    // Rows start at the edge after the first post-reset DECAY is accepted (edge 19).
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd0); // 19
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd0); // 20
    add(7'b1100001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd0); // 21 food+heal rise
    add(7'b1100001, 1'b0, 3'd0, 1'b0, 6'b000110, 8'd0); // 22 held
    add(7'b0000001, 1'b1, 3'd2, 1'b0, 6'b000100, 8'd0); // 23 HEAL first
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000100, 8'd0); // 24
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000100, 8'd0); // 25
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000100, 8'd0); // 26
    add(7'b0000001, 1'b1, 3'd3, 1'b0, 6'b000000, 8'd0); // 27 FOOD 4 later
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd0); // 28
    add(7'b0001001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd0); // 29 test rise
    add(7'b0000001, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 30 test mode on
    add(7'b0000101, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 31 light ignored
    add(7'b0000001, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 32 no decay
    add(7'b0000011, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 33 echo ignored
    add(7'b0000001, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 34
    add(7'b0010001, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 35 state rise
    add(7'b0000001, 1'b0, 3'd0, 1'b1, 6'b001000, 8'd0); // 36
    add(7'b0000001, 1'b1, 3'd4, 1'b1, 6'b000000, 8'd0); // 37 STATE_STEP
    add(7'b0000001, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 38
    add(7'b1000000, 1'b0, 3'd0, 1'b1, 6'b000000, 8'd0); // 39 food, ready low
    add(7'b0000000, 1'b0, 3'd0, 1'b1, 6'b000100, 8'd0); // 40
    add(7'b0000000, 1'b1, 3'd3, 1'b1, 6'b000000, 8'd0); // 41 FOOD offer stalls
    add(7'b1000000, 1'b1, 3'd3, 1'b1, 6'b000000, 8'd0); // 42
    add(7'b0000000, 1'b1, 3'd3, 1'b1, 6'b000100, 8'd0); // 43
    add(7'b1000000, 1'b1, 3'd3, 1'b1, 6'b000100, 8'd0); // 44
    add(7'b0000000, 1'b1, 3'd3, 1'b1, 6'b000100, 8'd1); // 45 coalesced
    add(7'b0010000, 1'b1, 3'd3, 1'b1, 6'b000100, 8'd1); // 46
    add(7'b0000000, 1'b1, 3'd3, 1'b1, 6'b001100, 8'd1); // 47
    add(7'b0001000, 1'b1, 3'd3, 1'b1, 6'b001100, 8'd1); // 48 test rise
    add(7'b0000000, 1'b1, 3'd3, 1'b0, 6'b000100, 8'd1); // 49 toggle clears STATE
    add(7'b0000000, 1'b1, 3'd3, 1'b0, 6'b000100, 8'd1); // 50
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000100, 8'd1); // 51 accepted
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000100, 8'd1); // 52
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000100, 8'd1); // 53
    add(7'b0000001, 1'b1, 3'd3, 1'b0, 6'b000000, 8'd1); // 54
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd1); // 55
    add(7'b0000101, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd1); // 56 light
    add(7'b0000011, 1'b0, 3'd0, 1'b0, 6'b010000, 8'd1); // 57 echo
    add(7'b0000001, 1'b1, 3'd5, 1'b0, 6'b100000, 8'd1); // 58
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b100000, 8'd1); // 59
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b100000, 8'd1); // 60
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b100000, 8'd1); // 61
    add(7'b0000001, 1'b1, 3'd6, 1'b0, 6'b000000, 8'd1); // 62
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd1); // 63
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd1); // 64
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000001, 8'd1); // 65 DECAY 16 after toggle
    add(7'b0000001, 1'b1, 3'd1, 1'b0, 6'b000000, 8'd1); // 66
    add(7'b0000001, 1'b0, 3'd0, 1'b0, 6'b000000, 8'd1); // 67

    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", cmd_if.cmd_valid, 0);
    chk("rst_code", cmd_if.cmd_code, 0);
    chk("rst_tm", test_mode, 0);
    chk("rst_pend", pending, 0);
    chk("rst_drop", drop_cnt, 0);
    #1 rst_n = 1'b1;

    step(7'b1000000);
    step(7'b0000000);
    chk("pre_food_pend", pending, 6'b000100);
    step(7'b0000000);
    chk("pre_food_valid", cmd_if.cmd_valid, 1);
    chk("pre_food_code", cmd_if.cmd_code, 3);
    step(7'b0100000);
    step(7'b0000000);
    chk("pre_heal_pend", pending, 6'b000010);
    chk("pre_offer_code", cmd_if.cmd_code, 3);

    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", cmd_if.cmd_valid, 0);
    chk("async_code", cmd_if.cmd_code, 0);
    chk("async_pend", pending, 0);
    chk("async_drop", drop_cnt, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      step(7'b0000001);
      if (cmd_if.cmd_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 17 && lat != 18) begin
      failures++;
      $display("FAIL decay_latency: got %0d expected 17 or 18", lat);
    end
    chk("decay_code", cmd_if.cmd_code, 1);
    step(7'b0000001);
    chk("decay_accept", cmd_if.cmd_valid, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in);
      chk($sformatf("row%0d_valid", i + 19), cmd_if.cmd_valid, tbl[i].valid);
      chk($sformatf("row%0d_code", i + 19), cmd_if.cmd_code, tbl[i].code);
      chk($sformatf("row%0d_tm", i + 19), test_mode, tbl[i].tm);
      chk($sformatf("row%0d_pend", i + 19), pending, tbl[i].pend);
      chk($sformatf("row%0d_drop", i + 19), drop_cnt, tbl[i].drop);
    end

    // Stall a HEAL offer and coalesce FOOD until the counter saturates.
    step(7'b0000000);
    step(7'b0000000);
    step(7'b0100000);
    repeat (4) step(7'b0000000);
    chk("sat_heal_valid", cmd_if.cmd_valid, 1);
    chk("sat_heal_code", cmd_if.cmd_code, 2);
    mono_ok = 1'b1;
    prev_drop = drop_cnt;
    for (int p = 0; p < 300; p++) begin
      step(7'b1000000);
      step(7'b0000000);
      if (drop_cnt < prev_drop) mono_ok = 1'b0;
      prev_drop = drop_cnt;
    end
    chk("sat_drop_255", drop_cnt, 255);
    for (int p = 0; p < 10; p++) begin
      step(7'b1000000);
      step(7'b0000000);
      if (drop_cnt < prev_drop) mono_ok = 1'b0;
      prev_drop = drop_cnt;
    end
    chk("sat_drop_hold", drop_cnt, 255);
    chk("sat_no_wrap", mono_ok, 1);
    chk("sat_offer_stable", cmd_if.cmd_code, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
